// File: rtl/color_pkg.sv
// color_pkg: shared codes, colour and controller state types for the Color FSM controller.
package color_pkg;
   typedef enum logic {Blue = 1'h0, Red = 1'h1} Color_state;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} ctrl_state_t;
   localparam logic [1:0] CMD_HOLD   = 2'h0;
   localparam logic [1:0] CMD_TOGGLE = 2'h1;
   localparam logic [1:0] STAT_BLUE  = 2'h1;
   localparam logic [1:0] STAT_RED   = 2'h2;
   function automatic logic [1:0] stat_code(input Color_state c);
      return (c == Red) ? STAT_RED : STAT_BLUE;
   endfunction
endpackage

// File: rtl/color_ctrl_timer.sv
// color_ctrl_timer: loadable WAIT-cycle counter; tc flags the TIMEOUT-th cycle (count == TIMEOUT-1).
module color_ctrl_timer #(
   parameter int TIMEOUT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   end
   assign tc = (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/color_fsm_ctrl.sv
// color_fsm_ctrl: request/response controller driving the two-state Color FSM.
// Optional toggle counter port enabled by COLOR_FSM_CTRL_TOGGLE_CNT_EN.
module color_fsm_ctrl
   import color_pkg::*;
#(
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_color,
   output logic             req_ready,
   output logic [1:0]       cmd,
   input  logic [1:0]       status,
   output logic             resp_valid,
   output logic             resp_err,
   input  logic             resp_ready,
   output logic             cur_color
`ifdef COLOR_FSM_CTRL_TOGGLE_CNT_EN
   ,
   output logic [CNT_W-1:0] toggle_cnt
`endif
);
   ctrl_state_t state, nxt;
   Color_state target;
   logic legal, tc;
   assign legal = (status == STAT_BLUE) || (status == STAT_RED);
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  if (req_valid) nxt = !legal ? ERR : (status == stat_code(Color_state'(req_color))) ? DONE : ISSUE;
         ISSUE: nxt = WAIT;
         // a match on the terminal-count cycle still counts as success
         WAIT:  nxt = (status == stat_code(target)) ? DONE : (!legal || tc) ? ERR : WAIT;
         DONE,
         ERR:   if (resp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // outputs are registered from the next state so they always agree with state
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         target     <= Red;
         cmd        <= CMD_HOLD;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         cur_color  <= 1'b1;
      end else begin
         state      <= nxt;
         cmd        <= (nxt == ISSUE) ? CMD_TOGGLE : CMD_HOLD;
         req_ready  <= (nxt == IDLE);
         resp_valid <= (nxt == DONE) || (nxt == ERR);
         resp_err   <= (nxt == ERR);
         if (state == IDLE && req_valid) target <= Color_state'(req_color);
         if (legal) cur_color <= status[1];
      end
   end
   color_ctrl_timer #(.TIMEOUT(TIMEOUT)) timer (
      .clk (clk),
      .rst (rst),
      .clr (state == ISSUE),
      .en  (state == WAIT),
      .tc  (tc)
   );
`ifdef COLOR_FSM_CTRL_TOGGLE_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) toggle_cnt <= '0;
      else if (state == ISSUE) toggle_cnt <= toggle_cnt + 1'b1;
   end
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif
endmodule
